// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver state encodings, frame width and the
// lowest usable clocks-per-bit setting. Used by both the transmitter and receiver.
package usart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;
    localparam int MIN_CPB   = 4;

    // Clamp a programmed clocks-per-bit value to the usable floor
    function automatic logic [11:0] floor_cpb(input logic [11:0] programmed,
                                              input logic [11:0] floor_value);
        return (programmed < floor_value) ? floor_value : programmed;
    endfunction

endpackage

// File: rtl/usart_sync.sv
// Multi-flop synchronizer for an asynchronous input pin. Resets to 1 so an
// idle-high serial line does not look like a falling edge right after reset.
module usart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] stages;

    // Shift the pin through the flop chain; stage 0 is the metastable one
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stages <= '1;
        end else begin
            stages[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign sync_out = stages[STAGES-1];

endmodule

// File: rtl/usart_rx.sv
// 8N1 serial receiver. Detects the start edge, checks the start bit at its
// midpoint to reject glitches, samples each data bit mid-bit LSB-first and
// hands the byte over on a valid/ready handshake with framing/overrun pulses.
module usart_rx #(
    parameter int MIN_CPB     = usart_pkg::MIN_CPB,
    parameter int SYNC_STAGES = 2
) (
    input  logic        serial_clock,
    input  logic        reset_n,
    input  logic [11:0] clocks_per_bit,
    input  logic        rx_pin,
    output logic [7:0]  data_out,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        framing_error,
    output logic        overrun
);

    import usart_pkg::*;

    logic                 rx_s;
    logic                 rx_prev;
    logic                 falling;
    logic [1:0]           state;
    logic [11:0]          counter;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [11:0]          cpb;
    logic [11:0]          half;

    usart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (serial_clock),
        .reset_n  (reset_n),
        .async_in (rx_pin),
        .sync_out (rx_s)
    );

    // Effective bit period (never below the floor) and the half-bit start offset
    always_comb begin
        cpb     = floor_cpb(clocks_per_bit, 12'(MIN_CPB));
        half    = cpb >> 1;
        falling = rx_prev & ~rx_s;
    end

    assign busy = (state != ST_IDLE);

    // Frame state machine, bit timing and the output handshake
    always_ff @(posedge serial_clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            counter       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            rx_prev       <= 1'b1;
            data_out      <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_prev       <= rx_s;
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (falling) begin
                        counter <= half - 12'd1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (counter == 12'd0) begin
                        if (!rx_s) begin
                            counter <= cpb - 12'd1;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        counter <= counter - 12'd1;
                    end
                end
                ST_DATA: begin
                    if (counter == 12'd0) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        counter   <= cpb - 12'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        counter <= counter - 12'd1;
                    end
                end
                ST_STOP: begin
                    if (counter == 12'd0) begin
                        state <= ST_IDLE;
                        if (rx_s) begin
                            if (!valid || ready) begin
                                data_out <= shift_reg;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        counter <= counter - 12'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: drives 8N1 frames on rx_pin and checks bytes,
// handshake behaviour, glitch rejection, framing/overrun pulses and reset.
module tb_usart_rx;

    logic        serial_clock = 1'b0;
    logic        reset_n      = 1'b0;
    logic [11:0] clocks_per_bit = 12'd16;
    logic        rx_pin       = 1'b1;
    logic        ready        = 1'b1;
    logic [7:0]  data_out;
    logic        valid;
    logic        busy;
    logic        framing_error;
    logic        overrun;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int cyc = 0;
    int fe_count = 0;
    int ov_count = 0;
    int busy_cycles = 0;
    int valid_cycles = 0;
    int valid_rise_cyc = 0;
    logic valid_q = 1'b0;
    logic [7:0] rx_bytes[$];

    int base_fe, base_ov, base_busy, base_valid, base_bytes, start_cyc;

    usart_rx dut (
        .serial_clock  (serial_clock),
        .reset_n       (reset_n),
        .clocks_per_bit(clocks_per_bit),
        .rx_pin        (rx_pin),
        .data_out      (data_out),
        .valid         (valid),
        .ready         (ready),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 serial_clock = ~serial_clock;

    // Event monitor on the inactive edge: pulse counts and accepted bytes
    always @(negedge serial_clock) begin
        cyc++;
        if (framing_error) fe_count++;
        if (overrun) ov_count++;
        if (busy) busy_cycles++;
        if (valid) valid_cycles++;
        if (valid && !valid_q) valid_rise_cyc = cyc;
        valid_q = valid;
        if (valid && ready) rx_bytes.push_back(data_out);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge serial_clock);
            #2;
        end
    endtask

    // Drive one 8N1 frame, bit_cycles clocks per bit, then leave the line idle
    task automatic applyStimulus(input logic [7:0] b, input logic stop_level, input int bit_cycles);
        rx_pin = 1'b0;
        tick(bit_cycles);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            tick(bit_cycles);
        end
        rx_pin = stop_level;
        tick(bit_cycles);
        rx_pin = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic snapshot();
        base_fe    = fe_count;
        base_ov    = ov_count;
        base_busy  = busy_cycles;
        base_valid = valid_cycles;
        base_bytes = rx_bytes.size();
    endtask

    initial begin
        logic [7:0] b81;

        // Reset state
        reset_n = 1'b0;
        tick(3);
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_framing_error", 32'(framing_error), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        tick(4);

        // Clean 0xA5 at cpb=16 with ready held high
        $display("[TB] frame 0xA5 at cpb=16");
        snapshot();
        start_cyc = cyc;
        applyStimulus(8'hA5, 1'b1, 16);
        tick(32);
        checkOutput("a5_count", 32'(rx_bytes.size() - base_bytes), 32'd1);
        checkOutput("a5_data", 32'(rx_bytes[base_bytes]), 32'hA5);
        checkOutput("a5_valid_one_cycle", 32'(valid_cycles - base_valid), 32'd1);
        checkOutput("a5_no_framing", 32'(fe_count - base_fe), 32'd0);
        checkOutput("a5_no_overrun", 32'(ov_count - base_ov), 32'd0);
        checkOutput("a5_latency", 32'((valid_rise_cyc - start_cyc) >= 152 && (valid_rise_cyc - start_cyc) <= 160), 32'd1);

        // Start-bit glitch: 5 low cycles then back high
        $display("[TB] start glitch");
        snapshot();
        rx_pin = 1'b0;
        tick(5);
        rx_pin = 1'b1;
        tick(40);
        checkOutput("glitch_busy_pulsed", 32'((busy_cycles - base_busy) >= 1 && (busy_cycles - base_busy) <= 15), 32'd1);
        checkOutput("glitch_idle", 32'(busy), 32'h0);
        checkOutput("glitch_no_byte", 32'(rx_bytes.size() - base_bytes), 32'd0);
        checkOutput("glitch_no_framing", 32'(fe_count - base_fe), 32'd0);

        // 0x3C with a low stop bit, then a good 0x5A
        $display("[TB] framing error then recovery");
        snapshot();
        applyStimulus(8'h3C, 1'b0, 16);
        tick(16);
        checkOutput("fe_pulse_once", 32'(fe_count - base_fe), 32'd1);
        checkOutput("fe_no_byte", 32'(rx_bytes.size() - base_bytes), 32'd0);
        checkOutput("fe_valid_low", 32'(valid), 32'h0);
        applyStimulus(8'h5A, 1'b1, 16);
        tick(32);
        checkOutput("recover_count", 32'(rx_bytes.size() - base_bytes), 32'd1);
        checkOutput("recover_data", 32'(rx_bytes[base_bytes]), 32'h5A);
        checkOutput("recover_no_new_fe", 32'(fe_count - base_fe), 32'd1);

        // Overrun: ready low across 0x11 and 0x22
        $display("[TB] overrun with ready low");
        ready = 1'b0;
        snapshot();
        applyStimulus(8'h11, 1'b1, 16);
        tick(16);
        applyStimulus(8'h22, 1'b1, 16);
        tick(32);
        checkOutput("ovr_valid_held", 32'(valid), 32'h1);
        checkOutput("ovr_data_kept", 32'(data_out), 32'h11);
        checkOutput("ovr_pulse_once", 32'(ov_count - base_ov), 32'd1);
        checkOutput("ovr_no_framing", 32'(fe_count - base_fe), 32'd0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        checkOutput("ovr_ready_clears", 32'(valid), 32'h0);
        ready = 1'b1;
        tick(4);

        // Back-to-back frames at cpb=4 with no idle gap
        $display("[TB] back-to-back at cpb=4");
        clocks_per_bit = 12'd4;
        tick(8);
        snapshot();
        applyStimulus(8'h00, 1'b1, 4);
        applyStimulus(8'hFF, 1'b1, 4);
        tick(20);
        checkOutput("b2b_count", 32'(rx_bytes.size() - base_bytes), 32'd2);
        checkOutput("b2b_first", 32'(rx_bytes[base_bytes]), 32'h00);
        checkOutput("b2b_second", 32'(rx_bytes[base_bytes+1]), 32'hFF);

        // clocks_per_bit below the floor behaves as 4 clocks per bit
        $display("[TB] clocks_per_bit floor");
        clocks_per_bit = 12'd2;
        tick(8);
        snapshot();
        applyStimulus(8'h96, 1'b1, 4);
        tick(20);
        checkOutput("floor_count", 32'(rx_bytes.size() - base_bytes), 32'd1);
        checkOutput("floor_data", 32'(rx_bytes[base_bytes]), 32'h96);

        // Break: line held low well beyond a frame
        $display("[TB] break condition");
        clocks_per_bit = 12'd16;
        tick(8);
        snapshot();
        rx_pin = 1'b0;
        tick(16 * 12);
        rx_pin = 1'b1;
        tick(32);
        checkOutput("break_fe_once", 32'(fe_count - base_fe), 32'd1);
        checkOutput("break_no_byte", 32'(rx_bytes.size() - base_bytes), 32'd0);

        // Reset during data bit 3 of 0x81; the sender abandons the frame too
        $display("[TB] reset mid-frame");
        snapshot();
        b81 = 8'h81;
        rx_pin = 1'b0;
        tick(16);
        for (int i = 0; i < 3; i++) begin
            rx_pin = b81[i];
            tick(16);
        end
        rx_pin = b81[3];
        tick(8);
        reset_n = 1'b0;
        rx_pin  = 1'b1;
        tick(1);
        checkOutput("midrst_busy_low", 32'(busy), 32'h0);
        checkOutput("midrst_valid_low", 32'(valid), 32'h0);
        reset_n = 1'b1;
        tick(40);
        checkOutput("midrst_no_byte", 32'(rx_bytes.size() - base_bytes), 32'd0);
        checkOutput("midrst_no_framing", 32'(fe_count - base_fe), 32'd0);
        applyStimulus(8'h7E, 1'b1, 16);
        tick(32);
        checkOutput("midrst_next_count", 32'(rx_bytes.size() - base_bytes), 32'd1);
        checkOutput("midrst_next_data", 32'(rx_bytes[base_bytes]), 32'h7E);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
